// File: rtl/maverickOne_pkg.sv
// Shared definitions for the maverickOne issue logic: register-file size and
// the lock tracker's FSM state type.
package maverickOne_pkg;

  localparam int NUM_REGS = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    BLOCKED = 1'b1
  } reg_lock_state_t;

endpackage

// File: rtl/reg_lock_tracker_count_ones.sv
// Parametric population count, used to report how many registers are locked.
module count_ones #(
  parameter int W  = 64,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/reg_lock_tracker.sv
// Registered lock vector, memory-busy flag and blocking-instruction FSM that
// close the feedback loop around the combinational reg_gnt_ckr.
module reg_lock_tracker
  import maverickOne_pkg::*;
#(
  parameter int NR  = NUM_REGS,
  parameter int NWB = 2,
  parameter int RW  = $clog2(NR),
  parameter int CW  = $clog2(NR + 1)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   issue_i,
  input  logic [RW-1:0]          issue_rd_i,
  input  logic                   issue_blocking_i,
  input  logic [NR-1:0]          gnt_locks_i,
  input  logic                   gnt_mem_busy_i,
  input  logic [NWB-1:0]         wb_valid_i,
  input  logic [NWB-1:0][RW-1:0] wb_rd_i,
  input  logic                   mem_done_i,
  input  logic                   blk_done_i,
  input  logic                   flush_i,
  output logic [NR-1:0]          locks_o,
  output logic                   mem_busy_o,
  output logic [CW-1:0]          lock_cnt_o,
  output logic                   idle_o
);

  reg_lock_state_t state_q, state_d;
  logic [NR-1:0]   locks_q, locks_d;
  logic            mem_busy_q, mem_busy_d;
  logic [NR-1:0]   clr;
  logic [NR-1:0]   base;
  logic            issue_ok;

  // Issues arriving while BLOCKED are dropped entirely.
  assign issue_ok = issue_i && (state_q == IDLE);

  // NOTE: every combinational output is given a default before any branch so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    clr = '0;
    for (int p = 0; p < NWB; p++) begin
      if (wb_valid_i[p] && (wb_rd_i[p] != '0)) begin
        clr[wb_rd_i[p]] = 1'b1;
      end
    end
  end

  assign base = issue_ok ? gnt_locks_i : locks_q;

  always_comb begin
    locks_d = base & ~clr;
    // The new destination lock is applied after the clear so it wins on WAW.
    if (issue_ok && (issue_rd_i != '0)) begin
      locks_d[issue_rd_i] = 1'b1;
    end
    locks_d[0] = 1'b0;
    if (flush_i) begin
      locks_d = '0;
    end
  end

  always_comb begin
    mem_busy_d = mem_busy_q;
    if (flush_i) begin
      mem_busy_d = 1'b0;
    end else if (issue_ok && gnt_mem_busy_i) begin
      mem_busy_d = 1'b1;
    end else if (mem_done_i) begin
      mem_busy_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue_i && issue_blocking_i) state_d = BLOCKED;
      BLOCKED: if (blk_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      locks_q    <= '0;
      mem_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      locks_q    <= locks_d;
      mem_busy_q <= mem_busy_d;
    end
  end

  count_ones #(
    .W  (NR),
    .CW (CW)
  ) u_count_ones (
    .vec (locks_q),
    .cnt (lock_cnt_o)
  );

  // BLOCKED presents every register as locked so the checker stalls all issue.
  assign locks_o    = (state_q == BLOCKED) ? '1 : locks_q;
  assign mem_busy_o = mem_busy_q;
  assign idle_o     = (state_q == IDLE) && (locks_q == '0) && !mem_busy_q;

endmodule

// File: doc/reg_lock_tracker.md
# reg_lock_tracker

Holds the architectural register lock vector and the memory-busy flag across cycles. It is the sequential state element that feeds `reg_gnt_ckr`: its `locks_o` / `mem_busy_o` drive that checker's `locks_i` / `mem_busy_i`. It captures the checker's updated lock vector whenever an instruction actually issues. Locks are released by writeback ports, and a blocking instruction is honoured by a two-state FSM until it completes.

## Interface
- `NR`, default `maverickOne_pkg::NUM_REGS` (64): number of architectural registers.
- `NWB`, default 2: number of writeback (unlock) ports.

- `clk_i`  in  1  system clock, rising edge.
- `arst_i`  in  1  asynchronous reset, active-high.
- `issue_i`  in  1  instruction granted by arbitration and issued this cycle.
- `issue_rd_i`  in  $clog2(NR)  destination register of the issuing instruction.
- `issue_blocking_i`  in  1  issuing instruction is blocking.
- `gnt_locks_i`  in  NR  lock vector produced by `reg_gnt_ckr` (`locks_o`).
- `gnt_mem_busy_i`  in  1  memory-busy flag produced by `reg_gnt_ckr` (`mem_busy_o`).
- `wb_valid_i`  in  NWB  writeback valid per port.
- `wb_rd_i`  in  NWB x $clog2(NR)  writeback register index per port.
- `mem_done_i`  in  1  outstanding memory operation completed.
- `blk_done_i`  in  1  blocking instruction retired.
- `flush_i`  in  1  pipeline flush; clears all state.
- `locks_o`  out  NR  lock vector to `reg_gnt_ckr.locks_i`.
- `mem_busy_o`  out  1  to `reg_gnt_ckr.mem_busy_i`.
- `lock_cnt_o`  out  $clog2(NR+1)  number of set bits in tracked `locks_q`.
- `idle_o`  out  1  no locks, memory not busy, FSM in IDLE.

## Operation
- State: `locks_q[NR-1:0]`, `mem_busy_q`, FSM `state_q` ∈ {IDLE, BLOCKED}.
- Unlock mask `clr` = OR over ports p with `wb_valid_i[p]` and `wb_rd_i[p] != 0` of `1 << wb_rd_i[p]`. Duplicate indices across ports are legal and idempotent.
- Base vector `base` = `gnt_locks_i` if (`issue_i` and state IDLE), else `locks_q`.
- Next value of each bit r of `locks_q`:
  - 0 if `flush_i`.
  - Otherwise 1 if `issue_i`, state IDLE, `r == issue_rd_i` and `r != 0`. A new lock beats a same-cycle writeback (WAW).
  - Otherwise `base[r] & ~clr[r]`.
- Bit 0 of `locks_q` is always 0. The IDLE/BLOCKED override below is the only way `locks_o[0]` reads 1.
- `mem_busy_q` next value:
  - 0 if `flush_i`.
  - Otherwise 1 if `issue_i` and `gnt_mem_busy_i` in IDLE. Set beats a same-cycle `mem_done_i`.
  - Otherwise 0 if `mem_done_i`.
  - Otherwise hold.
- FSM:
  - IDLE → BLOCKED on `issue_i & issue_blocking_i`.
  - BLOCKED → IDLE on `blk_done_i`.
  - Any state → IDLE on `flush_i`.
- `issue_i` in BLOCKED is ignored (state unchanged). Writebacks and `mem_done_i` are still processed in BLOCKED.
- Outputs:
  - `locks_o` = all ones in BLOCKED, else `locks_q`.
  - `mem_busy_o` = `mem_busy_q`.
  - `lock_cnt_o` = popcount(`locks_q`), which excludes the BLOCKED override.
  - `idle_o` = (state IDLE) & (`locks_q == 0`) & ~`mem_busy_q`.
- Priority: `flush_i` > issue set > writeback clear > hold.

## Timing
- All state updates on rising `clk_i`. Outputs are derived only from registered state: one-cycle latency from any input, and no combinational input→output paths. This matters because `reg_gnt_ckr` is combinational and sits in the feedback loop.
- Assertion of `arst_i` is immediate, regardless of clock: `locks_o`=0, `mem_busy_o`=0, `lock_cnt_o`=0, `idle_o`=1, state IDLE. Deassertion is synchronised externally.
- Reset mid-BLOCKED or with pending locks discards everything.
- `blk_done_i` together with `issue_i` in BLOCKED: exit to IDLE; the issue is ignored.
- `blk_done_i` in IDLE has no effect.

## Structure
- `maverickOne_pkg` provides `NUM_REGS` and gains `reg_lock_state_t` (enum IDLE, BLOCKED).
- One sub-module: `count_ones` (parametric popcount, width NR) for `lock_cnt_o`.
- Everything else is flat in `reg_lock_tracker`, instantiated alongside `reg_gnt_ckr`.

## Test plan
- Reset, then `issue_i`=1, `issue_rd_i`=5, `gnt_locks_i`=0x20 → next cycle `locks_o`=0x20, `lock_cnt_o`=1, `idle_o`=0. Then `wb_valid_i[0]`=1, `wb_rd_i[0]`=5 → `locks_o`=0, `idle_o`=1.
- `locks_q`=0x20; same cycle issue rd=5 and wb rd=5 → `locks_o`=0x20 (new lock wins). Issue rd=0 → bit 0 stays 0.
- Issue with `issue_blocking_i`=1 → `locks_o`=all ones, `lock_cnt_o` reflects tracked bits only. A further issue is ignored. Writeback rd=5 during BLOCKED clears the tracked bit. `blk_done_i` → `locks_o` equals the tracked vector.
- `gnt_mem_busy_i`=1 with issue and `mem_done_i`=1 same cycle → `mem_busy_o`=1. Next cycle `mem_done_i` alone → `mem_busy_o`=0.
- Two writeback ports: both rd=7 → bit 7 cleared. Ports rd=3 and rd=9 → both cleared in one cycle.
- `flush_i` with `locks_q`=0xFF0, BLOCKED, `mem_busy_q`=1 → all outputs at reset values. `arst_i` pulsed mid-cycle → outputs clear before the next edge.
- Closed loop with `reg_gnt_ckr` and random stimulus for 1000 cycles: every granted rd≠0 appears in `locks_o` one cycle later; no lock is lost or spuriously cleared.
